// File: rtl/axi_lite_csr_subordinate.sv
// AXI-Lite single-beat CSR subordinate: CTRL, STATUS and scratch registers.
// Optional CSR_IRQ_EN adds a W1C IRQ register at NUM_REGS and an irq output.
module axi_lite_csr_subordinate #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                  csr_clk,
    input  logic                  csr_rst,
    input  logic [ADDR_WIDTH-1:0] csr_awaddr,
    input  logic                  csr_awvalid,
    output logic                  csr_awready,
    input  logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic                  csr_wvalid,
    output logic                  csr_wready,
    input  logic                  csr_wlast,
    output logic [1:0]            csr_bresp,
    output logic                  csr_bvalid,
    input  logic                  csr_bready,
    input  logic [ADDR_WIDTH-1:0] csr_araddr,
    input  logic                  csr_arvalid,
    output logic                  csr_arready,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic [1:0]            csr_rresp,
    output logic                  csr_rvalid,
    input  logic                  csr_rready,
    output logic                  csr_rlast,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    input  logic [DATA_WIDTH-1:0] status_in
`ifdef CSR_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0]   LIM      = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t w_state_q;
    rstate_t r_state_q;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_held_q, w_held_q, wlast_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  arready_q, rvalid_q, rlast_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_fire, w_fire, aw_have, w_have, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last, wr_in_bank, wr_is_irq, wr_err, reg_we;
    logic                  ar_fire, rd_err;
    logic [DATA_WIDTH-1:0] rd_data;

    assign aw_fire = (w_state_q == W_IDLE) && csr_awvalid && awready_q;
    assign w_fire  = (w_state_q == W_IDLE) && csr_wvalid && wready_q;
    assign aw_have = aw_held_q || aw_fire;
    assign w_have  = w_held_q || w_fire;
    assign commit  = (w_state_q == W_IDLE) && aw_have && w_have;

    assign wr_addr = aw_held_q ? awaddr_q : csr_awaddr;
    assign wr_data = w_held_q ? wdata_q : csr_wdata;
    assign wr_last = w_held_q ? wlast_q : csr_wlast;

    assign wr_in_bank = ({1'b0, wr_addr} < LIM) && (wr_addr != A_STATUS);
`ifdef CSR_IRQ_EN
    assign wr_is_irq = ({1'b0, wr_addr} == LIM);
`else
    assign wr_is_irq = 1'b0;
`endif
    assign wr_err = !wr_last || !(wr_in_bank || wr_is_irq);
    assign reg_we = commit && !wr_err && wr_in_bank;

    assign ar_fire = (r_state_q == R_IDLE) && csr_arvalid && arready_q;

`ifdef CSR_IRQ_EN
    logic [DATA_WIDTH-1:0] irq_bits_q, irq_bits_d, irq_clr, status_prev_q;
    logic                  irq_q;

    assign irq_clr = (commit && !wr_err && wr_is_irq) ? wr_data : '0;
    // A rising status bit on the same edge as its clear keeps it set.
    assign irq_bits_d = (irq_bits_q & ~irq_clr) | (status_in & ~status_prev_q);

    always_ff @(posedge csr_clk) begin
        status_prev_q <= status_in;
        if (csr_rst) begin
            irq_bits_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_bits_q <= irq_bits_d;
            irq_q      <= |irq_bits_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if ({1'b0, csr_araddr} < LIM) begin
            rd_err = 1'b0;
            if (csr_araddr == A_STATUS) rd_data = status_in;
            else rd_data = regs_q[csr_araddr[IDX_W-1:0]];
        end
`ifdef CSR_IRQ_EN
        else if ({1'b0, csr_araddr} == LIM) begin
            rd_err  = 1'b0;
            rd_data = irq_bits_q;
        end
`endif
    end

    always_ff @(posedge csr_clk) begin
        if (csr_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge csr_clk) begin
        if (csr_rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_err ? SLVERR : OKAY;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                    end else begin
                        if (aw_fire) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= csr_awaddr;
                        end
                        if (w_fire) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= csr_wdata;
                            wlast_q  <= csr_wlast;
                        end
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                    end
                end
                W_RESP: begin
                    if (csr_bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        bresp_q   <= OKAY;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge csr_clk) begin
        if (csr_rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= 1'b1;
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_err ? SLVERR : OKAY;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (csr_rready) begin
                        r_state_q <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign csr_awready = awready_q;
    assign csr_wready  = wready_q;
    assign csr_bvalid  = bvalid_q;
    assign csr_bresp   = bresp_q;
    assign csr_arready = arready_q;
    assign csr_rvalid  = rvalid_q;
    assign csr_rlast   = rlast_q;
    assign csr_rresp   = rresp_q;
    assign csr_rdata   = rdata_q;
    assign ctrl_out    = regs_q[0];

endmodule

// File: tb/tb_axi_lite_csr_subordinate.sv
// Directed bench for axi_lite_csr_subordinate: vector table plus corner sequences.
// Build with +define+CSR_IRQ_EN to exercise the IRQ register.
module tb_axi_lite_csr_subordinate;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] awaddr, wdata, araddr, rdata, ctrl_out, status_in;
    logic       awvalid, awready, wvalid, wready, wlast;
    logic [1:0] bresp, rresp;
    logic       bvalid, bready, arvalid, arready, rvalid, rready, rlast;
`ifdef CSR_IRQ_EN
    logic       irq;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_lite_csr_subordinate #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(8)
    ) dut (
        .csr_clk(clk), .csr_rst(rst),
        .csr_awaddr(awaddr), .csr_awvalid(awvalid), .csr_awready(awready),
        .csr_wdata(wdata), .csr_wvalid(wvalid), .csr_wready(wready),
        .csr_wlast(wlast), .csr_bresp(bresp), .csr_bvalid(bvalid),
        .csr_bready(bready), .csr_araddr(araddr), .csr_arvalid(arvalid),
        .csr_arready(arready), .csr_rdata(rdata), .csr_rresp(rresp),
        .csr_rvalid(rvalid), .csr_rready(rready), .csr_rlast(rlast),
        .ctrl_out(ctrl_out), .status_in(status_in)
`ifdef CSR_IRQ_EN
        , .irq(irq)
`endif
    );

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        bit         last;
        logic [1:0] eresp;
        logic [7:0] edata;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input bit last, output logic [1:0] resp);
        int n = 0;
        awaddr = a; wdata = d; wlast = last;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        check("wr ready", {31'b0, awready && wready}, 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b1;
        check("wr bvalid N+1", {31'b0, bvalid}, 1);
        check("wr readies drop", {30'b0, awready, wready}, 0);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr bvalid clr", {31'b0, bvalid}, 0);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d,
                           output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        check("rd arready", {31'b0, arready}, 1);
        tick();
        arvalid = 1'b0;
        check("rd valid/last", {29'b0, rvalid, rlast, arready}, 32'h6);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd valid/last clr", {30'b0, rvalid, rlast}, 0);
    endtask

    initial begin
        vec_t       v[13];
        logic [7:0] d;
        logic [1:0] r;

        v[0]  = '{1, 8'd0, 8'hA5, 1, 2'b00, 8'h00};
        v[1]  = '{0, 8'd0, 8'h00, 1, 2'b00, 8'hA5};
        v[2]  = '{1, 8'd1, 8'hFF, 1, 2'b10, 8'h00};
        v[3]  = '{1, 8'd9, 8'h11, 1, 2'b10, 8'h00};
        v[4]  = '{1, 8'd3, 8'h77, 0, 2'b10, 8'h00};
        v[5]  = '{0, 8'd3, 8'h00, 1, 2'b00, 8'h00};
        v[6]  = '{0, 8'd9, 8'h00, 1, 2'b10, 8'h00};
        v[7]  = '{0, 8'd1, 8'h00, 1, 2'b00, 8'h5A};
        v[8]  = '{1, 8'd7, 8'hC3, 1, 2'b00, 8'h00};
        v[9]  = '{0, 8'd7, 8'h00, 1, 2'b00, 8'hC3};
`ifdef CSR_IRQ_EN
        v[10] = '{1, 8'd8, 8'h44, 1, 2'b00, 8'h00};
        v[11] = '{0, 8'd8, 8'h00, 1, 2'b00, 8'h00};
`else
        v[10] = '{1, 8'd8, 8'h44, 1, 2'b10, 8'h00};
        v[11] = '{0, 8'd8, 8'h00, 1, 2'b10, 8'h00};
`endif
        v[12] = '{0, 8'd255, 8'h00, 1, 2'b10, 8'h00};

        rst = 1'b1;
        awaddr = '0; wdata = '0; araddr = '0; status_in = 8'h5A;
        awvalid = 0; wvalid = 0; wlast = 1; bready = 0;
        arvalid = 0; rready = 0;
        tick(); tick();
        check("rst readies", {29'b0, awready, wready, arready}, 0);
        check("rst valids", {29'b0, bvalid, rvalid, rlast}, 0);
        check("rst resp/data", {20'b0, bresp, rresp, rdata}, 0);
        check("rst ctrl", {24'b0, ctrl_out}, 0);
        rst = 1'b0;
        tick();
        check("ready after rst", {29'b0, awready, wready, arready}, 32'h7);

        for (int i = 0; i < 13; i++) begin
            if (v[i].wr) begin
                do_write(v[i].addr, v[i].data, v[i].last, r);
                check($sformatf("vec%0d bresp", i), {30'b0, r}, {30'b0, v[i].eresp});
            end else begin
                do_read(v[i].addr, d, r);
                check($sformatf("vec%0d rresp", i), {30'b0, r}, {30'b0, v[i].eresp});
                check($sformatf("vec%0d rdata", i), {24'b0, d}, {24'b0, v[i].edata});
            end
        end
        check("ctrl_out A5", {24'b0, ctrl_out}, 32'hA5);

        // W three cycles ahead of AW, then a slow bready.
        wdata = 8'h3C; wvalid = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0;
        check("W early capture", {29'b0, awready, wready, bvalid}, 32'h4);
        tick(); tick();
        awaddr = 8'd2; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("late AW bvalid", {29'b0, bvalid, bresp}, 32'h4);
        awaddr = 8'd5; wdata = 8'hEE; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bhold%0d", i), {27'b0, bvalid, bresp, awready, wready}, 32'h10);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick();
        bready = 0;
        check("bready release", {29'b0, bvalid, awready, wready}, 32'h3);
        do_read(8'd5, d, r);
        check("blocked write", {22'b0, r, d}, 0);
        do_read(8'd2, d, r);
        check("scratch2", {22'b0, r, d}, 32'h3C);

        // STATUS sampled at the AR edge, held through slow rready.
        status_in = 8'h5A; araddr = 8'd1; arvalid = 1'b1;
        check("ar idle ready", {31'b0, arready}, 1);
        tick();
        arvalid = 1'b0; status_in = 8'h00;
        check("status sample", {24'b0, rdata}, 32'h5A);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rhold%0d", i), {22'b0, rvalid, arready, rdata}, 32'h25A);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rready release", {29'b0, rvalid, rlast, arready}, 32'h1);

        // Read and write to one register on the same edge.
        do_write(8'd4, 8'h11, 1'b1, r);
        awaddr = 8'd4; wdata = 8'h22; araddr = 8'd4;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("same edge both", {30'b0, bvalid, rvalid}, 32'h3);
        check("same edge old", {24'b0, rdata}, 32'h11);
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        do_read(8'd4, d, r);
        check("same edge new", {24'b0, d}, 32'h22);

        // Reset with B and R both pending.
        awaddr = 8'd6; wdata = 8'h99; araddr = 8'd0;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("pend before rst", {30'b0, bvalid, rvalid}, 32'h3);
        rst = 1'b1;
        tick();
        check("rst drops valid", {29'b0, bvalid, rvalid, rlast}, 0);
        check("rst ctrl mid", {24'b0, ctrl_out}, 0);
        tick();
        check("rst readies mid", {29'b0, awready, wready, arready}, 0);
        rst = 1'b0;
        tick();
        check("clean readies", {29'b0, awready, wready, arready}, 32'h7);
        do_read(8'd2, d, r);
        check("scratch cleared", {24'b0, d}, 0);

`ifdef CSR_IRQ_EN
        status_in = 8'h00;
        tick(); tick();
        check("irq idle", {31'b0, irq}, 0);
        status_in = 8'h04;
        tick();
        check("irq rise", {31'b0, irq}, 1);
        do_write(8'd8, 8'h04, 1'b1, r);
        check("irq clr resp", {30'b0, r}, 0);
        check("irq cleared", {31'b0, irq}, 0);
        status_in = 8'h00;
        tick();
        awaddr = 8'd8; wdata = 8'h04; wlast = 1;
        awvalid = 1; wvalid = 1; status_in = 8'h04;
        tick();
        awvalid = 0; wvalid = 0;
        check("irq set wins", {31'b0, irq}, 1);
        bready = 1;
        tick();
        bready = 0;
        do_read(8'd8, d, r);
        check("irq reg", {22'b0, r, d}, 32'h04);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_csr_subordinate.md
Name: axi_lite_csr_subordinate

Overview:
AXI-Lite subordinate (responder) that terminates the single-beat AXI-Lite traffic issued by the team's AXI-Lite manager. It owns a small CSR bank: a control register driven out to the datapath, a read-only status register sampled from the datapath, and general scratch registers. The write path (AW/W/B) and read path (AR/R) run as independent FSMs. It is the register front end for FIFO-style blocks.

Parameters:
ADDR_WIDTH, 8, address width; one register per address.
DATA_WIDTH, 8, register and data-bus width.
NUM_REGS, 8, implemented registers, 2..2**ADDR_WIDTH.

Ports:
csr_clk  in  1  single clock.
csr_rst  in  1  synchronous reset, active-high.
csr_awaddr  in  ADDR_WIDTH  write address.
csr_awvalid  in  1  write address valid.
csr_awready  out  1  write address ready.
csr_wdata  in  DATA_WIDTH  write data.
csr_wvalid  in  1  write data valid.
csr_wready  out  1  write data ready.
csr_wlast  in  1  write last; must be 1, since transfers are single-beat.
csr_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
csr_bvalid  out  1  write response valid.
csr_bready  in  1  write response ready.
csr_araddr  in  ADDR_WIDTH  read address.
csr_arvalid  in  1  read address valid.
csr_arready  out  1  read address ready.
csr_rdata  out  DATA_WIDTH  read data.
csr_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
csr_rvalid  out  1  read data valid.
csr_rready  in  1  read data ready.
csr_rlast  out  1  read last; always 1 while rvalid is high.
ctrl_out  out  DATA_WIDTH  contents of CTRL register.
status_in  in  DATA_WIDTH  live status value from the datapath.

Behaviour:
- Address map: 0 = CTRL (RW, drives ctrl_out). 1 = STATUS (RO, reads status_in). 2..NUM_REGS-1 = scratch (RW). Addresses at or above NUM_REGS are unmapped.
- Reset (any csr_clk edge with csr_rst=1): all registers 0; all ready outputs 0; bvalid and rvalid 0; bresp and rresp 00; rdata 0; rlast 0; both FSMs return to IDLE.
- Ready outputs rise at the first edge with csr_rst=0.
- Reset asserted mid-transaction aborts it: a pending B or R is dropped and no register write occurs.
- Write FSM, W_IDLE:
  - awready=1 until AW has been captured; wready=1 until W has been captured. AW and W may arrive in either order or in the same cycle.
  - Each ready drops at its capture edge.
  - At the edge where both AW and W are held, move to W_RESP: perform the write, and assert bvalid in the next cycle.
- Write FSM, W_RESP:
  - bvalid stays high; bresp stays stable until bready=1.
  - On the bready edge, move to W_IDLE: bvalid=0 and awready/wready=1 from the next cycle.
  - Minimum latency: AW+W handshake edge N gives bvalid=1 in cycle N+1.
- Write SLVERR, no register change, if the address is unmapped, the address is STATUS, or wlast=0.
- Read FSM, R_IDLE:
  - arready=1.
  - On the AR handshake edge: latch rdata and rresp, set rvalid=1 and rlast=1, drop arready, move to R_DATA.
  - STATUS returns status_in as sampled at the handshake edge.
  - An unmapped address returns rdata=0 with rresp=10.
- Read FSM, R_DATA:
  - rdata, rresp and rlast are held stable until rready=1.
  - On the rready edge: rvalid=0, rlast=0, back to R_IDLE.
  - arready returns the following cycle.
- Read and write to the same register committing on the same edge: the read returns the old value.
- The read and write FSMs never stall each other.
- No outstanding-transaction queue: one write and one read in flight at most.

Optional Feature:
- Macro: CSR_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and register IRQ at address NUM_REGS, so the mapped range becomes 0..NUM_REGS.
  - IRQ[i] is set at each edge where status_in[i] rises (0→1), compared with its value on the previous edge.
  - A write of 1 to IRQ bit i clears that bit (W1C); writes of 0 have no effect.
  - If a set and a clear occur on the same edge, set wins.
  - irq is the OR of all IRQ bits, registered. IRQ resets to 0.
- Undefined: no irq port; address NUM_REGS is unmapped and returns SLVERR.

Test Plan:
- Write 0xA5 to address 0 with AW and W in the same cycle → awready and wready fall the next cycle; bvalid=1 with bresp=00 one cycle after the handshake; ctrl_out=0xA5. A subsequent read of address 0 gives rdata=0xA5, rresp=00, rlast=1.
- W issued 3 cycles before AW, address 2, data 0x3C; bready held low 4 cycles → bvalid holds with bresp=00 for 4 cycles; no new AW/W accepted until the bready edge. A read of address 2 returns 0x3C.
- Write 0xFF to address 1, then write 0x11 to address 9 (NUM_REGS=8), then a separate write to address 3 with wlast=0 → each gives bresp=10; registers unchanged. A read of address 9 gives rresp=10 and rdata=0x00.
- status_in=0x5A; read address 1 with rready low 2 cycles while status_in changes to 0x00 → rdata stays 0x5A until the rready edge; arready=0 throughout.
- Assert csr_rst while bvalid=1 and rvalid=1 → both are 0 after the reset edge; ctrl_out=0x00; all ready outputs are 0 during reset and 1 at the first clean edge.
- CSR_IRQ_EN defined: status_in[2] rises 0→1 → irq=1. Writing 0x04 to address 8 clears it to irq=0. If a rise and the clear land on the same edge, irq stays 1.
